// File: rtl/fifo.sv
// rtl/fifo.sv - dual-clock first-word-fall-through FIFO with Gray-coded pointer crossing
// Optional feature macro: FIFO_ZERO_ON_EMPTY_EN (drives data_out to zero while empty).
module fifo #(
  parameter int BUFFER_SIZE = 128,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clock_in,
  input  logic                  rst_in_n,
  input  logic                  clock_out,
  input  logic                  rst_out_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ack
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_SIZE];

  // Write-domain state
  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] rd_sync1_q, rd_sync2_q;
  logic          full_q, full_d;
  logic          push;

  // Read-domain state
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] wr_sync1_q, wr_sync2_q;
  logic          empty;
  logic          pop;

  // Next write pointer; full is judged on the post-push pointer so it rises on the filling edge
  always_comb begin
    push      = data_in_valid && !full_q;
    wr_bin_d  = wr_bin_q + (push ? PW'(1) : PW'(0));
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    full_d    = (wr_gray_d == {~rd_sync2_q[PW-1:PW-2], rd_sync2_q[PW-3:0]});
  end

  // Write pointers, full flag and the two-flop read-pointer synchronizer
  always_ff @(posedge clock_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      full_q     <= 1'b0;
      rd_sync1_q <= '0;
      rd_sync2_q <= '0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      full_q     <= full_d;
      rd_sync1_q <= rd_gray_q;
      rd_sync2_q <= rd_sync1_q;
    end
  end

  // Storage is written only; contents survive reset
  always_ff @(posedge clock_in) begin
    if (push) begin
      mem_q[wr_bin_q[AW-1:0]] <= data_in;
    end
  end

  // Empty compares against the synchronized (possibly stale) write pointer, so it errs toward empty
  always_comb begin
    empty     = (rd_gray_q == wr_sync2_q);
    pop       = !empty && data_out_ack;
    rd_bin_d  = rd_bin_q + (pop ? PW'(1) : PW'(0));
    rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
  end

  // Read pointers and the two-flop write-pointer synchronizer
  always_ff @(posedge clock_out or negedge rst_out_n) begin
    if (!rst_out_n) begin
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      wr_sync1_q <= '0;
      wr_sync2_q <= '0;
    end else begin
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      wr_sync1_q <= wr_gray_q;
      wr_sync2_q <= wr_sync1_q;
    end
  end

  // Head word falls through combinationally from the current read address
  always_comb begin
    data_in_full   = full_q;
    data_out_valid = !empty;
`ifdef FIFO_ZERO_ON_EMPTY_EN
    data_out       = empty ? '0 : mem_q[rd_bin_q[AW-1:0]];
`else
    data_out       = mem_q[rd_bin_q[AW-1:0]];
`endif
  end

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - randomized self-checking bench for the dual-clock FIFO
`timescale 1ns/1ps
module tb_fifo;
  localparam int DW = 32;
  localparam int BS = 128;

  logic          clock_in = 1'b0;
  logic          clock_out = 1'b0;
  logic          rst_in_n = 1'b0;
  logic          rst_out_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_out_ack = 1'b0;
  logic          data_in_full;
  logic [DW-1:0] data_out;
  logic          data_out_valid;

  int  errors = 0;
  int  checks = 0;
  bit  checking = 1'b0;
  real in_half = 5.0;
  real out_half = 7.0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] popped[$];

  fifo #(.BUFFER_SIZE(BS), .DATA_WIDTH(DW)) dut (
    .clock_in(clock_in), .rst_in_n(rst_in_n), .clock_out(clock_out), .rst_out_n(rst_out_n),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_full(data_in_full),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ack(data_out_ack)
  );

  // clock_in edges land on whole ns, clock_out edges on .25 ns, so the domains never share an instant
  always #(in_half) clock_in = ~clock_in;
  initial begin
    #0.25;
    forever #(out_half) clock_out = ~clock_out;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference queue: a word enters when offered while not full, leaves when acked while shown
  always @(posedge clock_in) begin
    if (rst_in_n && data_in_valid && !data_in_full) q.push_back(data_in);
  end
  always @(posedge clock_out) begin
    if (rst_out_n && data_out_valid && data_out_ack) begin
      popped.push_back(data_out);
      if (q.size() != 0) void'(q.pop_front());
    end
  end

  // Invariants: shown data is the oldest unread word; full never lags a full queue
  always @(negedge clock_out or negedge clock_in) begin
    if (checking) begin
      if (data_out_valid) begin
        check("valid_implies_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) check("data_out_head", 64'(data_out), 64'(q[0]));
      end
      if (q.size() == BS) check("full_when_queue_full", 64'(data_in_full), 64'd1);
      check("occupancy_bound", 64'(q.size() <= BS), 64'd1);
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    int tries;
    bit go;
    tries = 0;
    @(negedge clock_in);
    data_in = w;
    data_in_valid = 1'b1;
    forever begin
      go = !data_in_full;
      @(negedge clock_in);
      if (go) break;
      tries++;
      if (tries > 20000) begin
        check("push_timeout", 64'd1, 64'd0);
        break;
      end
    end
    data_in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    data_out_ack = 1'b1;
    while ((q.size() != 0 || data_out_valid) && n < limit) begin
      @(negedge clock_out);
      n++;
    end
    repeat (4) @(negedge clock_out);
    data_out_ack = 1'b0;
    check("drain_in_time", 64'(n < limit), 64'd1);
  endtask

  task automatic stream(input real ih, input real oh, input int words, input logic [DW-1:0] base);
    int guard;
    in_half = ih;
    out_half = oh;
    popped.delete();
    guard = 0;
    fork
      begin
        for (int i = 0; i < words; i++) begin
          if ($urandom_range(3) == 0) @(negedge clock_in);
          push_word(base + DW'(i));
        end
      end
      begin
        while (popped.size() < words && guard < 40000) begin
          @(negedge clock_out);
          data_out_ack = ($urandom_range(3) != 0);
          guard++;
        end
        data_out_ack = 1'b0;
      end
    join
    check("stream_count", 64'(popped.size()), 64'(words));
    for (int i = 0; i < popped.size(); i++) check("stream_order", 64'(popped[i]), 64'(base + DW'(i)));
  endtask

  initial begin
    int n;
    logic [DW-1:0] w;

    #20.6;
    rst_in_n = 1'b1;
    rst_out_n = 1'b1;
    repeat (3) @(negedge clock_in);
    checking = 1'b1;
    check("reset_full", 64'(data_in_full), 64'd0);
    check("reset_valid", 64'(data_out_valid), 64'd0);
`ifdef FIFO_ZERO_ON_EMPTY_EN
    check("reset_data_zero", 64'(data_out), 64'd0);
`endif

    // Five words at a slow writer with a fast, always-acking reader
    in_half = 50.0;
    out_half = 1.0;
    popped.delete();
    data_out_ack = 1'b1;
    for (int i = 1; i <= 5; i++) push_word(DW'(i));
    repeat (3) @(negedge clock_in);
    check("five_count", 64'(popped.size()), 64'd5);
    for (int i = 0; i < popped.size(); i++) check("five_value", 64'(popped[i]), 64'(i + 1));
    check("five_valid_after", 64'(data_out_valid), 64'd0);
    data_out_ack = 1'b0;

    // Fill to capacity with no reader, then try to overfill
    in_half = 5.0;
    out_half = 7.0;
    popped.delete();
    for (int i = 0; i < BS; i++) push_word(32'h100 + DW'(i));
    check("fill_model_size", 64'(q.size()), 64'd128);
    check("fill_full", 64'(data_in_full), 64'd1);
    @(negedge clock_in);
    data_in = 32'hDEAD;
    data_in_valid = 1'b1;
    repeat (5) @(negedge clock_in);
    data_in_valid = 1'b0;
    check("overfill_ignored", 64'(q.size()), 64'd128);
    check("overfill_still_full", 64'(data_in_full), 64'd1);

    // One pop must release full within three clock_in edges
    @(negedge clock_out);
    data_out_ack = 1'b1;
    @(negedge clock_out);
    data_out_ack = 1'b0;
    n = 0;
    while (data_in_full && n < 3) begin
      @(posedge clock_in);
      #0.1;
      n++;
    end
    check("full_falls_within_3", 64'(data_in_full), 64'd0);

    // Fast reader empties everything in order, nothing extra
    out_half = 1.0;
    drain(2000);
    check("drain_count", 64'(popped.size()), 64'd128);
    check("drain_first", 64'(popped[0]), 64'h100);
    check("drain_last", 64'(popped[popped.size()-1]), 64'h17F);
    check("drain_empty", 64'(data_out_valid), 64'd0);

    // Long streams crossing pointer wrap at both extreme clock ratios
    stream(1.0, 25.0, 310, 32'h1000);
    stream(25.0, 1.0, 310, 32'h2000);
    drain(2000);

    // Single word latency and immediate empty after its ack
    in_half = 25.0;
    out_half = 1.0;
    w = 32'hCAFEF00D;
    @(negedge clock_in);
    data_in = w;
    data_in_valid = 1'b1;
    @(posedge clock_in);
    #0.1;
    data_in_valid = 1'b0;
    n = 0;
    while (!data_out_valid && n < 3) begin
      @(posedge clock_out);
      #0.1;
      n++;
    end
    check("single_valid_within_3", 64'(data_out_valid), 64'd1);
    check("single_data", 64'(data_out), 64'hCAFEF00D);
    @(negedge clock_out);
    data_out_ack = 1'b1;
    @(posedge clock_out);
    #0.1;
    check("single_empty_after_ack", 64'(data_out_valid), 64'd0);
    data_out_ack = 1'b0;
    check("final_model_empty", 64'(q.size()), 64'd0);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/fifo.md
# fifo

Dual-clock first-in/first-out buffer carrying DATA_WIDTH-bit words from the `clock_in` domain to an asynchronous `clock_out` domain. Producer pushes with a valid/full handshake. Consumer sees first-word-fall-through data with a valid/ack handshake. Pointers cross domains as Gray codes through two-flop synchronizers. The block sits between a producer and a consumer running on unrelated clocks.

## Interface
- BUFFER_SIZE, 128: depth in words; must be a power of two, ≥ 4.
- DATA_WIDTH, 32: word width in bits.

- clock_in  input  1  write-domain clock.
- rst_in_n  input  1  reset: rst_in_n, asynchronous, active-low; clock clock_in. Resets write-domain state.
- clock_out  input  1  read-domain clock.
- rst_out_n  input  1  asynchronous active-low reset of read-domain state.
- data_in  input  DATA_WIDTH  word to push.
- data_in_valid  input  1  push request.
- data_in_full  output  1  FIFO full; push ignored while high.
- data_out  output  DATA_WIDTH  head-of-queue word (FWFT).
- data_out_valid  output  1  head word present (not empty).
- data_out_ack  input  1  consumer accepts head word.

## Operation
- Storage: BUFFER_SIZE × DATA_WIDTH array.
  - Written on `clock_in`.
  - Read asynchronously at the read address.
- Pointers: binary and Gray write/read pointers, each log2(BUFFER_SIZE)+1 bits (8 bits at default). The low bits address memory; the MSB is the wrap flag.
- Push: at posedge `clock_in`, if `data_in_valid && !data_in_full`:
  - store `data_in` at the write address;
  - increment the write pointer, wrapping modulo 2·BUFFER_SIZE.
- Pop: at posedge `clock_out`, if `data_out_valid && data_out_ack`, increment the read pointer.
- `data_out` = mem[read address] at all times. Next word appears combinationally after a pop.
- Full: write Gray pointer equals the read Gray pointer synchronized into `clock_in`, with its two MSBs inverted. Registered value.
- Empty: read Gray pointer equals the write Gray pointer synchronized into `clock_out`. `data_out_valid` = !empty.
- Valid with data_in_full high: no write, no pointer change, no data lost or duplicated.
- Ack with data_out_valid low: ignored.
- Data order is strictly preserved; every accepted word is delivered exactly once.
- Reset:
  - rst_in_n low: write pointers and the read-pointer synchronizer clear to 0; data_in_full = 0.
  - rst_out_n low: read pointers and the write-pointer synchronizer clear to 0; data_out_valid = 0.
  - Memory contents are not reset.
  - Asserting one reset mid-operation without the other is not supported. Both resets must overlap to restart cleanly.

## Timing
- Write → read visibility: data_out_valid rises 2–3 posedges of `clock_out` after the accepting `clock_in` edge (two-flop synchronizer).
- Pop → not-full: data_in_full falls 2–3 posedges of `clock_in` after the popping `clock_out` edge.
- Full is pessimistic, empty is pessimistic; neither may be late.
- Full asserts on the same `clock_in` edge that writes the BUFFER_SIZE-th unread word. The next valid cycle is blocked.
- Empty (data_out_valid low) takes effect combinationally right after the `clock_out` edge that pops the last word.
- Simultaneous push and pop in the same instant: both take effect; occupancy unchanged.
- Only one pointer bit changes per increment in Gray form, including at wrap (255→0 at default).

## Configuration
- Macro `FIFO_ZERO_ON_EMPTY_EN`:
  - Defined: data_out is forced to all-zeros whenever data_out_valid is 0.
  - Undefined: data_out shows mem[read address] regardless of empty, and is meaningless while data_out_valid = 0.

## Test plan
- Reset then no traffic -> data_in_full=0, data_out_valid=0 in both domains; with FIFO_ZERO_ON_EMPTY_EN, data_out=0.
- Push 0x00000001..0x00000005 at 100 ns clock_in, ack held 1, clock_out at 2 ns -> data_out yields 1,2,3,4,5 in order; data_out_valid low afterwards.
- Push 128 words with ack=0 -> data_in_full rises on the write of the 128th word; the 129th valid is ignored. After one pop, full falls within 3 clock_in edges.
- Then ack with a fast clock_out -> 128 words read out in exact order, with no 129th value present.
- Continuous push/pop for more than 300 words, crossing pointer wrap, at clock ratios 1:25 and 25:1 -> every word matches the sequence number; no drop or duplicate.
- Single word pushed while clock_out is fast -> data_out_valid rises within 3 clock_out edges with data_out=word; it drops right after the acking edge.
